// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - operand/result register stage around the MULT32 combinational multiplier
module mult_hilo_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] mcnd,
    output logic [DATA_WIDTH-1:0] mplr,
    input  logic [DATA_WIDTH-1:0] mult_hi,
    input  logic [DATA_WIDTH-1:0] mult_lo,
    input  logic                  wr_hi,
    input  logic                  wr_lo,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mcnd  <= '0;
            mplr  <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Direct writes and a new multiply may share an edge; the
                    // multiply's capture later overwrites both registers.
                    if (wr_hi) hi <= wr_data;
                    if (wr_lo) lo <= wr_data;
                    if (start) begin
                        mcnd  <= op_a;
                        mplr  <= op_b;
                        cnt   <= CNT_W'(LATENCY);
                        busy  <= 1'b1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        hi    <= mult_hi;
                        lo    <= mult_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - self-checking bench for mult_hilo_unit with a MULT32 stand-in
module tb_mult_hilo_unit;
    localparam int DW  = 32;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst, start, wr_hi, wr_lo;
    logic [DW-1:0] op_a, op_b, wr_data;
    logic [DW-1:0] mcnd, mplr, mult_hi, mult_lo, hi, lo;
    logic          busy, done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_hi, m_lo, m_mcnd, m_mplr;
    logic [63:0]   m_prod;
    int            m_left;
    logic          m_done;

    always #5 clk = ~clk;

    // Unsigned 32x32 product standing in for MULT32.
    assign {mult_hi, mult_lo} = 64'(mcnd) * 64'(mplr);

    mult_hilo_unit #(.DATA_WIDTH(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .mcnd(mcnd), .mplr(mplr), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference: a multiply is "m_left edges from landing"; zero means idle.
    task automatic model_edge();
        m_done = 1'b0;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_mcnd = '0; m_mplr = '0; m_prod = '0; m_left = 0;
        end else if (m_left == 0) begin
            if (wr_hi) m_hi = wr_data;
            if (wr_lo) m_lo = wr_data;
            if (start) begin
                m_mcnd = op_a;
                m_mplr = op_b;
                m_prod = 64'(op_a) * 64'(op_b);
                m_left = LAT;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_hi   = m_prod[63:32];
                m_lo   = m_prod[31:0];
                m_done = 1'b1;
            end
        end
    endtask

    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'(m_left != 0));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_hi"},   hi,   m_hi);
        chk({tag, "_lo"},   lo,   m_lo);
        chk({tag, "_mcnd"}, mcnd, m_mcnd);
        chk({tag, "_mplr"}, mplr, m_mplr);
    endtask

    task automatic quiet();
        rst = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    initial begin
        int done_cnt;
        quiet();
        op_a = '0; op_b = '0; wr_data = '0;
        m_hi = 'x; m_lo = 'x; m_mcnd = 'x; m_mplr = 'x; m_prod = '0; m_left = 0;

        rst = 1'b1;
        cyc("reset0");
        cyc("reset1");
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        rst = 1'b0;

        // 1: 9*8
        op_a = 9; op_b = 8; start = 1'b1;
        cyc("t1_start");
        quiet();
        repeat (LAT) cyc("t1_wait");
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_hi", hi, 32'h0);
        chk("t1_lo", lo, 32'h48);
        chk("t1_mcnd", mcnd, 32'h9);
        chk("t1_mplr", mplr, 32'h8);

        // 2: 0x10000^2, then 3*5 issued in the DONE cycle
        op_a = 32'h0001_0000; op_b = 32'h0001_0000; start = 1'b1;
        cyc("t2a_start");
        quiet();
        repeat (LAT) cyc("t2a_wait");
        chk("t2a_hi", hi, 32'h1);
        chk("t2a_lo", lo, 32'h0);
        op_a = 3; op_b = 5; start = 1'b1;
        cyc("t2b_start");
        chk("t2b_busy", 32'(busy), 32'h1);
        quiet();
        repeat (LAT) cyc("t2b_wait");
        chk("t2b_hi", hi, 32'h0);
        chk("t2b_lo", lo, 32'hF);

        // 3: 7*6 with START and WR_HI poked during WAIT
        op_a = 7; op_b = 6; start = 1'b1;
        cyc("t3_start");
        quiet();
        done_cnt = 0;
        cyc("t3_w1");
        start = 1'b1; op_a = 2; op_b = 2; wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        cyc("t3_w2");
        quiet();
        for (int i = 0; i < LAT + 2; i++) begin
            cyc("t3_tail");
            if (done) done_cnt++;
        end
        chk("t3_hi", hi, 32'h0);
        chk("t3_lo", lo, 32'h2A);
        chk("t3_done_count", 32'(done_cnt), 32'h1);

        // 4: direct writes in IDLE
        wr_hi = 1'b1; wr_data = 32'h1234_5678;
        cyc("t4_wrhi");
        quiet();
        wr_lo = 1'b1; wr_data = 32'h9ABC_DEF0;
        cyc("t4_wrlo");
        quiet();
        cyc("t4_hold");
        chk("t4_hi", hi, 32'h1234_5678);
        chk("t4_lo", lo, 32'h9ABC_DEF0);
        chk("t4_done", 32'(done), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);

        // 5: reset mid-operation, then a clean multiply
        op_a = 9; op_b = 8; start = 1'b1;
        cyc("t5_start");
        quiet();
        cyc("t5_w1");
        rst = 1'b1;
        cyc("t5_rst");
        quiet();
        chk("t5_hi", hi, 32'h0);
        chk("t5_lo", lo, 32'h0);
        chk("t5_mcnd", mcnd, 32'h0);
        repeat (LAT) cyc("t5_idle");
        op_a = 3; op_b = 3; start = 1'b1;
        cyc("t5b_start");
        quiet();
        repeat (LAT) cyc("t5b_wait");
        chk("t5b_lo", lo, 32'h9);

        // 6: same-edge WR_LO and START
        wr_lo = 1'b1; wr_data = 32'hAAAA; op_a = 4; op_b = 4; start = 1'b1;
        cyc("t6_start");
        quiet();
        chk("t6_lo_early", lo, 32'hAAAA);
        repeat (LAT) cyc("t6_wait");
        chk("t6_hi", hi, 32'h0);
        chk("t6_lo", lo, 32'h10);

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom % 64) == 0;
            start   = ($urandom % 3) == 0;
            wr_hi   = ($urandom % 5) == 0;
            wr_lo   = ($urandom % 5) == 0;
            op_a    = $urandom;
            op_b    = $urandom;
            wr_data = $urandom;
            cyc("rand");
        end
        quiet();
        repeat (LAT + 1) cyc("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
